vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster timing generator; VGA_CLK_DIV_EN adds a /2 pixel-clock divider
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_end,
    output logic       frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] hcount;
    logic [9:0] vcount;
    // Registered copy of reset so outputs are forced on clk edges only and the
    // counters hold at (0,0) for the first cycle after release.
    logic       rst_q;
    logic       tick;

`ifdef VGA_CLK_DIV_EN
    logic div;

    always_ff @(posedge clk) begin
        if (reset || rst_q) begin
            div <= 1'b0;
        end else begin
            div <= ~div;
        end
    end

    assign tick = div & ~rst_q;
`else
    assign tick = ~rst_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rst_q  <= 1'b1;
            hcount <= 10'd0;
            vcount <= 10'd0;
        end else begin
            rst_q <= 1'b0;
            if (tick) begin
                if (hcount == H_LAST) begin
                    hcount <= 10'd0;
                    if (vcount == V_LAST) begin
                        vcount <= 10'd0;
                    end else begin
                        vcount <= vcount + 10'd1;
                    end
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    logic visible;
    logic last_pixel;

    assign visible    = (hcount < H_VIS) && (vcount < V_VIS);
    assign last_pixel = tick && (hcount == H_LAST);

    always_comb begin
        pix_tick  = tick;
        video_on  = 1'b0;
        x         = 10'd0;
        y         = 9'd0;
        hsync     = 1'b1;
        vsync     = 1'b1;
        line_end  = 1'b0;
        frame_end = 1'b0;
        if (!rst_q) begin
            video_on  = visible;
            x         = visible ? hcount : 10'd0;
            y         = visible ? vcount[8:0] : 9'd0;
            hsync     = !((hcount >= HS_START) && (hcount < HS_END));
            vsync     = !((vcount >= VS_START) && (vcount < VS_END));
            line_end  = last_pixel;
            frame_end = last_pixel && (vcount == V_LAST);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen against an arithmetic raster model
module tb_vga_timing_gen;

    localparam int HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int VV = 20, VF = 3, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
`ifdef VGA_CLK_DIV_EN
    localparam int DIV = 2;
    localparam int RUN_FRAMES = 1;
`else
    localparam int DIV = 1;
    localparam int RUN_FRAMES = 2;
`endif
    localparam int CPF = DIV * HT * VT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_tick;
    logic [9:0] x;
    logic [8:0] y;
    logic       video_on, hsync, vsync, line_end, frame_end;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .x(x), .y(y),
        .video_on(video_on), .hsync(hsync), .vsync(vsync),
        .line_end(line_end), .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [8:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic       le;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   t = 0;
    bit   in_rst = 1'b0;

    // t counts clk cycles since reset release; the raster position follows by division.
    function automatic exp_t model(input int tc, input bit r);
        exp_t e;
        int   p, h, v;
        bit   tk;
        e = '0;
        if (r) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            return e;
        end
        tk = (DIV == 1) ? 1'b1 : ((tc % 2) == 1);
        p  = tc / DIV;
        h  = p % HT;
        v  = (p / HT) % VT;
        e.tick = tk;
        e.von  = (h < HV) && (v < VV);
        e.x    = e.von ? 10'(h) : 10'd0;
        e.y    = e.von ? 9'(v) : 9'd0;
        e.hs   = !((h >= HV + HF) && (h < HV + HF + HS));
        e.vs   = !((v >= VV + VF) && (v < VV + VF + VS));
        e.le   = tk && (h == HT - 1);
        e.fe   = e.le && (v == VT - 1);
        return e;
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
        total++;
        if (act !== req) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, req);
        end
    endtask

    task automatic step(input logic r);
        reset = r;
        @(posedge clk);
        if (r) begin
            in_rst = 1'b1;
            t = 0;
        end else if (in_rst) begin
            in_rst = 1'b0;
            t = 0;
        end else begin
            t++;
        end
        #1;
        exp_q.push_back(model(t, in_rst));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pix_tick",  {9'd0, pix_tick},  {9'd0, e.tick});
                chk("x",         x,                 e.x);
                chk("y",         {1'b0, y},         {1'b0, e.y});
                chk("video_on",  {9'd0, video_on},  {9'd0, e.von});
                chk("hsync",     {9'd0, hsync},     {9'd0, e.hs});
                chk("vsync",     {9'd0, vsync},     {9'd0, e.vs});
                chk("line_end",  {9'd0, line_end},  {9'd0, e.le});
                chk("frame_end", {9'd0, frame_end}, {9'd0, e.fe});
            end
        end
    end

    initial begin : stimulus
        int  p, n;
        bit  found;
        repeat (5) step(1'b1);
        repeat (RUN_FRAMES * CPF + 2000) step(1'b0);

        // reset for one cycle mid-frame at (300,5)
        found = 1'b0;
        for (int i = 0; i < CPF; i++) begin
            p = t / DIV;
            if ((p % HT) == 300 && ((p / HT) % VT) == 5 && (t % DIV) == 0) begin
                found = 1'b1;
                break;
            end
            step(1'b0);
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL reach_300_5: got not reached want reached");
        end
        step(1'b1);
        repeat (3000) step(1'b0);

        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 1999) == 0) begin
                n = $urandom_range(1, 3);
                repeat (n) step(1'b1);
            end else begin
                step(1'b0);
            end
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
